// File: rtl/sb_pkg.sv
// sb_pkg: shared definitions for the system-bus interconnect.
//   SB_N_SLAVES / SB_REGION_*  address-region decode geometry (addr[31:24])
//   sb_state_t                 interconnect FSM states
//   sb_req_t                   latched copy of the granted master's request
//   region_onehot()            region index -> one-hot slave request vector
package sb_pkg;

  localparam int SB_N_SLAVES   = 8;
  localparam int SB_REGION_MSB = 31;
  localparam int SB_REGION_LSB = 24;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } sb_state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } sb_req_t;

  function automatic logic [SB_N_SLAVES-1:0] region_onehot(input logic [2:0] region);
    region_onehot         = '0;
    region_onehot[region] = 1'b1;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: two-way round-robin arbiter for the system bus.
//   clk, rst  system clock, synchronous active-high reset
//   req       per-master request
//   advance   one-cycle strobe: a transaction of master 'served' completed
//   served    index of the master whose transaction just completed
//   grant     index of the master that wins this cycle
//   valid     at least one master is requesting
module sb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       grant,
  output logic       valid
);

  // Index of the master that wins a tie; 0 after reset.
  logic ptr;

  // After each completion the other master gets priority, so neither can starve.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  // Tie goes to the pointer; a lone requester always wins.
  always_comb begin
    valid = |req;
    grant = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master, eight-slave system-bus interconnect.
// One transaction in flight at a time, decoded by addr[31:24]; unmapped
// regions and slaves that stay silent for TIMEOUT cycles get an error reply.
//   clk_i, rst_i                   clock, synchronous active-high reset
//   m_req_i/we/be/addr/wd          per-master request (master k in slice k)
//   m_ready_o, m_rd_o, m_err_o     one-cycle completion pulse and response
//   s_req_o                        one-hot slave request
//   s_we/be/addr/wd_o              request fields towards the slaves
//   s_rd_i, s_ready_i              per-slave read data (slice k) and ready
module sys_bus_arbiter
  import sb_pkg::*;
#(
  parameter logic [7:0]  SLAVE_MASK = 8'b1000_1001,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_RDATA  = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   m_req_i,
  input  logic [1:0]   m_we_i,
  input  logic [7:0]   m_be_i,
  input  logic [63:0]  m_addr_i,
  input  logic [63:0]  m_wd_i,
  output logic [1:0]   m_ready_o,
  output logic [31:0]  m_rd_o,
  output logic         m_err_o,
  output logic [7:0]   s_req_o,
  output logic         s_we_o,
  output logic [3:0]   s_be_o,
  output logic [31:0]  s_addr_o,
  output logic [31:0]  s_wd_o,
  input  logic [255:0] s_rd_i,
  input  logic [7:0]   s_ready_i
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  sb_state_t   state, state_nx;
  sb_req_t     lat, lat_nx;
  logic        gnt, gnt_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        err, err_nx;
  logic [31:0] rd, rd_nx;
  logic        advance;

  logic        arb_idx, arb_valid;
  sb_req_t     sel;
  logic [7:0]  sel_region;
  logic        sel_mapped;
  logic [2:0]  region;
  logic        addr_hi_unused;

  sb_rr_arbiter u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (m_req_i),
    .advance (advance),
    .served  (gnt),
    .grant   (arb_idx),
    .valid   (arb_valid)
  );

  // Request of whichever master the arbiter currently favours.
  assign sel.we     = m_we_i[arb_idx];
  assign sel.be     = arb_idx ? m_be_i[7:4]    : m_be_i[3:0];
  assign sel.addr   = arb_idx ? m_addr_i[63:32] : m_addr_i[31:0];
  assign sel.wd     = arb_idx ? m_wd_i[63:32]   : m_wd_i[31:0];
  assign sel_region = sel.addr[SB_REGION_MSB:SB_REGION_LSB];
  // Regions >= 8 must not alias onto the mask through their low bits.
  assign sel_mapped = (sel_region < 8'(SB_N_SLAVES)) && SLAVE_MASK[sel_region[2:0]];

  // Once latched, the address is known to lie in region 0..7.
  assign region         = lat.addr[SB_REGION_LSB+2:SB_REGION_LSB];
  assign addr_hi_unused = ^lat.addr[SB_REGION_MSB:SB_REGION_LSB+3];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      lat   <= '0;
      gnt   <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
      rd    <= '0;
    end else begin
      state <= state_nx;
      lat   <= lat_nx;
      gnt   <= gnt_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
      rd    <= rd_nx;
    end
  end

  // Next-state logic. Ready is tested before the timeout so a reply arriving
  // in the last allowed cycle still counts as a success.
  always_comb begin
    state_nx = state;
    lat_nx   = lat;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    err_nx   = err;
    rd_nx    = rd;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          lat_nx = sel;
          gnt_nx = arb_idx;
          cnt_nx = '0;
          if (sel_mapped) begin
            state_nx = ACCESS;
          end else begin
            err_nx   = 1'b1;
            rd_nx    = ERR_RDATA;
            state_nx = RESP;
          end
        end
      end
      ACCESS: begin
        cnt_nx = cnt + 8'd1;
        if (s_ready_i[region]) begin
          rd_nx    = s_rd_i[{region, 5'd0} +: 32];
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt == CNT_LAST) begin
          rd_nx    = ERR_RDATA;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        advance  = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by state so everything reads 0 outside its window.
  always_comb begin
    s_req_o   = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wd_o    = '0;
    m_ready_o = '0;
    m_rd_o    = '0;
    m_err_o   = 1'b0;
    if (state == ACCESS) begin
      s_req_o  = region_onehot(region);
      s_we_o   = lat.we;
      s_be_o   = lat.be;
      s_addr_o = {8'd0, lat.addr[23:0]};
      s_wd_o   = lat.wd;
    end
    if (state == RESP) begin
      m_ready_o = gnt ? 2'b10 : 2'b01;
      m_rd_o    = rd;
      m_err_o   = err;
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: self-checking bench for sys_bus_arbiter.
// Table of single-master transactions, hand sequences for arbitration and
// reset-in-flight, then two randomized masters against a rule-level model.
module tb_sys_bus_arbiter;

  localparam int         TIMEOUT = 16;
  localparam logic [7:0] MASK    = 8'b1000_1001;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   m_req_i, m_we_i;
  logic [7:0]   m_be_i;
  logic [63:0]  m_addr_i, m_wd_i;
  logic [1:0]   m_ready_o;
  logic [31:0]  m_rd_o;
  logic         m_err_o;
  logic [7:0]   s_req_o;
  logic         s_we_o;
  logic [3:0]   s_be_o;
  logic [31:0]  s_addr_o, s_wd_o;
  logic [255:0] s_rd_i;
  logic [7:0]   s_ready_i;

  int          checks = 0;
  int          errors = 0;
  int          dly[8];
  int          hold[8];
  logic [31:0] sdata[8];
  int          last_served;
  logic        last_other_waiting;
  logic [1:0]  rand_done;

  typedef struct {
    int          master;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    int          sdly;
    logic [31:0] sdata;
    int          exp_edges;
    int          exp_sreq_cycles;
    logic [7:0]  exp_sreq;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  sys_bus_arbiter #(
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TIMEOUT),
    .ERR_RDATA  (32'h0000_0000)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_be_i    (m_be_i),
    .m_addr_i  (m_addr_i),
    .m_wd_i    (m_wd_i),
    .m_ready_o (m_ready_o),
    .m_rd_o    (m_rd_o),
    .m_err_o   (m_err_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wd_o    (s_wd_o),
    .s_rd_i    (s_rd_i),
    .s_ready_i (s_ready_i)
  );

  // Slave models: slave k answers in its (dly[k]+1)-th requested cycle.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 8; k++) begin
      if (s_req_o[k]) begin
        s_ready_i[k] = (hold[k] == dly[k]);
        hold[k]      = hold[k] + 1;
      end else begin
        s_ready_i[k] = 1'b0;
        hold[k]      = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setSlave(input int k, input int d, input logic [31:0] data);
    dly[k]             = d;
    sdata[k]           = data;
    s_rd_i[k*32 +: 32] = data;
  endtask

  // One isolated transaction; scrambles the master inputs after grant to
  // show that only the latched copy reaches the slaves.
  task automatic applyStimulus(input vec_t v, input string tag);
    int          m, edges, sreq_cycles;
    logic        got, side_bad, err;
    logic [1:0]  rdy;
    logic [31:0] rd;
    m = v.master;
    if ((v.addr >> 24) < 8) setSlave(int'(v.addr[26:24]), v.sdly, v.sdata);
    m_we_i[m]            = v.we;
    m_be_i[m*4 +: 4]     = v.be;
    m_addr_i[m*32 +: 32] = v.addr;
    m_wd_i[m*32 +: 32]   = v.wd;
    m_req_i[m]           = 1'b1;
    edges = 0; sreq_cycles = 0; got = 0; side_bad = 0;
    rdy = 2'b00; err = 1'b0; rd = '0;
    while (edges < 300 && !got) begin
      @(posedge clk); #1;
      edges++;
      if (s_req_o != 8'h00) begin
        sreq_cycles++;
        if (s_req_o != v.exp_sreq || s_we_o != v.we || s_be_o != v.be ||
            s_addr_o != {8'd0, v.addr[23:0]} || s_wd_o != v.wd)
          side_bad = 1'b1;
      end
      if (m_ready_o != 2'b00) begin
        got = 1'b1; rdy = m_ready_o; err = m_err_o; rd = m_rd_o;
        m_req_i[m] = 1'b0;
      end else if (edges == 1) begin
        m_addr_i[m*32 +: 32] = $urandom;
        m_wd_i[m*32 +: 32]   = $urandom;
        m_be_i[m*4 +: 4]     = 4'($urandom);
        m_we_i[m]            = ~v.we;
      end
    end
    m_req_i[m] = 1'b0;
    checkOutput({tag, "_edges"}, edges, v.exp_edges);
    checkOutput({tag, "_sreq_cycles"}, sreq_cycles, v.exp_sreq_cycles);
    checkOutput({tag, "_slave_side"}, {31'd0, side_bad}, 32'd0);
    checkOutput({tag, "_ready"}, {30'd0, rdy}, (m == 1) ? 32'd2 : 32'd1);
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    if (v.chk_rd) checkOutput({tag, "_rd"}, rd, v.exp_rd);
    @(posedge clk); #1;
    checkOutput({tag, "_ready_pulse"}, {30'd0, m_ready_o}, 32'd0);
  endtask

  // Randomized master: each completion is compared with the response the
  // address map and slave latencies dictate, plus the alternation rule.
  task automatic driveMaster(input int k);
    logic [7:0]  reg8;
    logic [31:0] addr, exp_rd;
    logic        we, mapped, exp_err, got;
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 6))
        0: reg8 = 8'h00;
        1: reg8 = 8'h03;
        2: reg8 = 8'h07;
        3: reg8 = 8'h01;
        4: reg8 = 8'h05;
        5: reg8 = 8'h09;
        default: reg8 = 8'h80;
      endcase
      addr    = {reg8, 24'($urandom)};
      we      = 1'($urandom_range(0, 1));
      mapped  = (reg8 < 8'd8) && MASK[reg8[2:0]];
      exp_err = !mapped || (dly[reg8[2:0]] >= TIMEOUT);
      exp_rd  = exp_err ? 32'h0 : sdata[reg8[2:0]];
      m_we_i[k]            = we;
      m_be_i[k*4 +: 4]     = 4'($urandom);
      m_addr_i[k*32 +: 32] = addr;
      m_wd_i[k*32 +: 32]   = $urandom;
      m_req_i[k]           = 1'b1;
      got = 1'b0;
      for (int e = 0; e < 400 && !got; e++) begin
        @(posedge clk); #1;
        if (m_ready_o[k]) got = 1'b1;
      end
      if (!got) begin
        checkOutput($sformatf("rand_m%0d_wait", k), 32'd0, 32'd1);
        m_req_i[k] = 1'b0;
        break;
      end
      checkOutput($sformatf("rand_m%0d_err", k), {31'd0, m_err_o}, {31'd0, exp_err});
      if (!we) checkOutput($sformatf("rand_m%0d_rd", k), m_rd_o, exp_rd);
      if (last_other_waiting)
        checkOutput("rand_alternation", k, 1 - last_served);
      last_served        = k;
      last_other_waiting = m_req_i[1-k];
      m_req_i[k] = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_done[k] = 1'b1;
  endtask

  initial begin
    vec_t        v;
    logic        got, seen;
    logic [1:0]  exp_order[4];

    //            m  we be     addr          wd            sdly sdata         edg cyc sreq   err rd            chk
    vecs[0] = '{0, 0, 4'hF, 32'h0000_0010, 32'h0,         0,   32'hCAFE_0001, 2,  1,  8'h01, 0, 32'hCAFE_0001, 1};
    vecs[1] = '{1, 1, 4'h3, 32'h0300_0004, 32'h1234_5678, 5,   32'hDEAD_0003, 7,  6,  8'h08, 0, 32'h0,         0};
    vecs[2] = '{0, 0, 4'hF, 32'h0500_0000, 32'h0,         0,   32'h5555_5555, 1,  0,  8'h00, 1, 32'h0,         1};
    vecs[3] = '{0, 0, 4'hF, 32'h0000_0000, 32'h0,         255, 32'h1111_1111, 17, 16, 8'h01, 1, 32'h0,         1};
    vecs[4] = '{0, 0, 4'hF, 32'h0000_0000, 32'h0,         15,  32'h2222_2222, 17, 16, 8'h01, 0, 32'h2222_2222, 1};
    vecs[5] = '{1, 0, 4'hF, 32'h0900_0000, 32'h0,         0,   32'h0,         1,  0,  8'h00, 1, 32'h0,         1};
    vecs[6] = '{1, 0, 4'hC, 32'h07AB_CDEF, 32'h0,         2,   32'h7777_0007, 4,  3,  8'h80, 0, 32'h7777_0007, 1};
    vecs[7] = '{0, 0, 4'hF, 32'h8000_0000, 32'h0,         0,   32'h0,         1,  0,  8'h00, 1, 32'h0,         1};
    vecs[8] = '{1, 0, 4'hF, 32'h0000_0004, 32'h0,         16,  32'h3333_3333, 17, 16, 8'h01, 1, 32'h0,         1};

    rst_i = 1'b1; m_req_i = '0; m_we_i = '0; m_be_i = '0; m_addr_i = '0; m_wd_i = '0;
    s_rd_i = '0; s_ready_i = '0; last_served = -1; last_other_waiting = 1'b0; rand_done = '0;
    for (int k = 0; k < 8; k++) begin
      setSlave(k, 0, 32'h0);
      hold[k] = 0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_ready", {30'd0, m_ready_o}, 32'd0);
    checkOutput("rst_m_rd", m_rd_o, 32'd0);
    checkOutput("rst_m_err", {31'd0, m_err_o}, 32'd0);
    checkOutput("rst_s_req", {24'd0, s_req_o}, 32'd0);
    checkOutput("rst_s_we", {31'd0, s_we_o}, 32'd0);
    checkOutput("rst_s_be", {28'd0, s_be_o}, 32'd0);
    checkOutput("rst_s_addr", s_addr_o, 32'd0);
    checkOutput("rst_s_wd", s_wd_o, 32'd0);
    rst_i = 1'b0;

    // Both masters from reset to region 7: M0 first, then strict alternation
    $display("[TB] arbitration sequence");
    setSlave(7, 0, 32'h7777_AAAA);
    m_addr_i  = {32'h0700_0100, 32'h0700_0000};
    m_be_i    = 8'hFF;
    m_req_i   = 2'b11;
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int e = 0; e < 100 && !got; e++) begin
        @(posedge clk); #1;
        if (m_ready_o != 2'b00) got = 1'b1;
      end
      checkOutput($sformatf("rr_order_%0d", n), {30'd0, got ? m_ready_o : 2'b00}, {30'd0, exp_order[n]});
      if (!got || n == 3) begin
        m_req_i = 2'b00;
      end else begin
        m_req_i = m_req_i & ~m_ready_o;
        @(posedge clk); #1;
        m_req_i = 2'b11;
      end
    end
    @(posedge clk); #1;

    // Table of isolated transactions
    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset while in ACCESS: transaction dropped, no completion pulse
    $display("[TB] reset during access");
    setSlave(0, 255, 32'h0);
    m_we_i[0] = 1'b0; m_addr_i[31:0] = 32'h0000_0020; m_req_i[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstacc_in_access", {24'd0, s_req_o}, 32'h01);
    rst_i = 1'b1; m_req_i = 2'b00;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("rstacc_s_req", {24'd0, s_req_o}, 32'd0);
    checkOutput("rstacc_m_ready", {30'd0, m_ready_o}, 32'd0);
    checkOutput("rstacc_m_err", {31'd0, m_err_o}, 32'd0);
    checkOutput("rstacc_m_rd", m_rd_o, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_ready_o != 2'b00 || s_req_o != 8'h00) seen = 1'b1;
    end
    checkOutput("rstacc_quiet", {31'd0, seen}, 32'd0);
    v = '{0, 0, 4'hF, 32'h0000_0040, 32'h0, 0, 32'hC0DE_0000, 2, 1, 8'h01, 0, 32'hC0DE_0000, 1};
    applyStimulus(v, "post_reset");

    // Randomized two-master traffic
    $display("[TB] random traffic");
    for (int k = 0; k < 8; k++)
      setSlave(k, ($urandom_range(0, 3) == 0) ? 20 : int'($urandom_range(0, 4)), $urandom);
    fork
      driveMaster(0);
      driveMaster(1);
      begin
        for (int c = 0; c < 20000 && rand_done != 2'b11; c++) begin
          @(posedge clk); #1;
          if (s_req_o != 8'h00)
            checkOutput("rand_sreq_legal",
                        {31'd0, ($onehot(s_req_o) && ((s_req_o & ~MASK) == 8'h00))}, 32'd1);
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
